dmem_arbiter: RTL and testbench

//  Shares the single-port 32x32 data memory between two requesters: port 0 (core load/store)
//  and port 1 (debug/loader).

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0) and the
// debug/loader (port 1). One transaction at a time: IDLE accepts, ACCESS drives memory, RESP replies.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_we,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_we,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,

  output logic              mem_read_flag,
  output logic              mem_write_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              rr_ptr;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    winner = rr_ptr;
    if (r0_req_valid && !r1_req_valid)      winner = 1'b0;
    else if (r1_req_valid && !r0_req_valid) winner = 1'b1;
    sel_we    = winner ? r1_req_we    : r0_req_we;
    sel_addr  = winner ? r1_req_addr  : r0_req_addr;
    sel_wdata = winner ? r1_req_wdata : r0_req_wdata;
  end

  assign r0_req_ready = (state == IDLE) && r0_req_valid && !winner;
  assign r1_req_ready = (state == IDLE) && r1_req_valid &&  winner;
  assign busy         = (state != IDLE);

  // NOTE: non-blocking assignments only, so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= 1'b0;
      grant_id       <= 1'b0;
      r0_rsp_valid   <= 1'b0;
      r1_rsp_valid   <= 1'b0;
      r0_rsp_rdata   <= '0;
      r1_rsp_rdata   <= '0;
      mem_read_flag  <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req_valid || r1_req_valid) begin
            grant_id       <= winner;
            mem_write_flag <= sel_we;
            mem_read_flag  <= ~sel_we;
            mem_addr       <= sel_addr;
            mem_wdata      <= sel_wdata;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_write_flag still carries this access's direction during ACCESS.
          mem_read_flag  <= 1'b0;
          mem_write_flag <= 1'b0;
          if (grant_id) begin
            r1_rsp_valid <= 1'b1;
            r1_rsp_rdata <= mem_write_flag ? '0 : mem_rdata;
          end else begin
            r0_rsp_valid <= 1'b1;
            r0_rsp_rdata <= mem_write_flag ? '0 : mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          r0_rsp_valid <= 1'b0;
          r1_rsp_valid <= 1'b0;
          rr_ptr       <= ~grant_id;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a 32-word memory model plus a transaction-level reference
// (expected grant order, response timing and read data) derived from the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid;
  logic [AW-1:0] r0_req_addr;
  logic [DW-1:0] r0_req_wdata, r0_rsp_rdata;
  logic          r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid;
  logic [AW-1:0] r1_req_addr;
  logic [DW-1:0] r1_req_wdata, r1_rsp_rdata;
  logic          mem_read_flag, mem_write_flag, busy, grant_id;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem     [32];
  logic [DW-1:0] ref_mem [32];
  logic          ref_rr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory device: read data is garbage whenever the read flag is low.
  always @(posedge clk) if (mem_write_flag) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read_flag ? mem[mem_addr] : 32'hA5A5_5A5A;

  // Memory-side rule watcher: flags never both high, never high while idle.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((mem_read_flag && mem_write_flag) || ((mem_read_flag || mem_write_flag) && !busy)) begin
        bad++;
        $display("FAIL mem_flags cyc=%0d rd=%b wr=%b busy=%b (need exclusive and only while busy)",
                 cyc, mem_read_flag, mem_write_flag, busy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d (need bench to finish)", cyc);
    $fatal(1, "timeout");
  end

  function automatic req_t rand_req();
    req_t q;
    q.we    = 1'($urandom_range(0, 1));
    q.addr  = AW'($urandom_range(0, 31));
    q.wdata = $urandom;
    return q;
  endfunction

  // Runs every presented request to completion, one accept per idle slot, checking each phase.
  task automatic serve(input logic v0, input logic v1, input req_t q0, input req_t q1,
                       output int t0, output int t1);
    logic [1:0]    pend, rdy, exp_vec, got_vec;
    int            budget, w, exp_w;
    req_t          q;
    logic [DW-1:0] exp_d, got_d;
    pend = {v1, v0};
    t0 = -1; t1 = -1; budget = 0;
    r0_req_valid = v0; r0_req_we = q0.we; r0_req_addr = q0.addr; r0_req_wdata = q0.wdata;
    r1_req_valid = v1; r1_req_we = q1.we; r1_req_addr = q1.addr; r1_req_wdata = q1.wdata;
    while (pend != 2'b00) begin
      #1;
      rdy = {r1_req_ready, r0_req_ready};
      if (rdy == 2'b00) begin
        budget++;
        if (budget > 12) begin
          total++; bad++;
          $display("FAIL serve_timeout pend=%b (need a ready within 12 cycles)", pend);
          r0_req_valid = 1'b0; r1_req_valid = 1'b0; pend = 2'b00;
        end else @(negedge clk);
      end else begin
        exp_w = (pend == 2'b11) ? int'(ref_rr) : (pend[0] ? 0 : 1);
        exp_vec = 2'b00; exp_vec[exp_w] = 1'b1;
        total++;
        if (rdy !== exp_vec) begin
          bad++; $display("FAIL grant_ready got=%b need=%b", rdy, exp_vec);
        end
        w = rdy[0] ? 0 : 1;
        q = (w == 1) ? q1 : q0;
        if (w == 0) t0 = cyc; else t1 = cyc;
        @(negedge clk);
        if (w == 0) r0_req_valid = 1'b0; else r1_req_valid = 1'b0;
        pend[w] = 1'b0;
        #1;
        total++;
        if ({busy, grant_id, mem_write_flag, mem_read_flag, mem_addr, mem_wdata, r0_rsp_valid, r1_rsp_valid}
            !== {1'b1, 1'(w), q.we, ~q.we, q.addr, q.wdata, 2'b00}) begin
          bad++;
          $display("FAIL access got busy=%b gid=%b wr=%b rd=%b addr=%0d wd=%h need gid=%0d we=%b addr=%0d wd=%h",
                   busy, grant_id, mem_write_flag, mem_read_flag, mem_addr, mem_wdata, w, q.we, q.addr, q.wdata);
        end
        @(negedge clk); #1;
        exp_vec = 2'b00; exp_vec[w] = 1'b1;
        exp_d   = q.we ? '0 : ref_mem[q.addr];
        got_vec = {r1_rsp_valid, r0_rsp_valid};
        got_d   = (w == 1) ? r1_rsp_rdata : r0_rsp_rdata;
        total++;
        if ({got_vec, got_d, mem_read_flag, mem_write_flag} !== {exp_vec, exp_d, 2'b00}) begin
          bad++;
          $display("FAIL response got rsp=%b rdata=%h flags=%b%b need rsp=%b rdata=%h flags=00",
                   got_vec, got_d, mem_read_flag, mem_write_flag, exp_vec, exp_d);
        end
        if (q.we) ref_mem[q.addr] = q.wdata;
        ref_rr = (w == 0);
        @(negedge clk); #1;
        total++;
        if ({busy, r0_rsp_valid, r1_rsp_valid} !== 3'b000) begin
          bad++;
          $display("FAIL back_to_idle got busy=%b rsp=%b%b need 0 00", busy, r1_rsp_valid, r0_rsp_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({grant_id, mem_addr, mem_wdata, r0_rsp_rdata, r1_rsp_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_values got gid=%b addr=%0d wd=%h rd0=%h rd1=%h need all 0",
               grant_id, mem_addr, mem_wdata, r0_rsp_rdata, r1_rsp_rdata);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({busy, r0_req_ready, r1_req_ready, mem_read_flag, mem_write_flag, r0_rsp_valid, r1_rsp_valid} !== 7'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d got busy=%b rdy=%b%b flags=%b%b rsp=%b%b need all 0", i,
                 busy, r1_req_ready, r0_req_ready, mem_read_flag, mem_write_flag, r1_rsp_valid, r0_rsp_valid);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    int t0, t1;
    serve(1'b1, 1'b0, '{we: 1'b1, addr: 5'd5, wdata: 32'hDEADBEEF}, '0, t0, t1);
    serve(1'b1, 1'b0, '{we: 1'b0, addr: 5'd5, wdata: 32'h0}, '0, t0, t1);
  endtask

  task automatic test_fill();
    int   t0, t1;
    req_t q;
    for (int i = 0; i < 32; i++) begin
      q = '{we: 1'b1, addr: AW'(i), wdata: $urandom};
      if (i % 2 == 0) serve(1'b1, 1'b0, q, '0, t0, t1);
      else            serve(1'b0, 1'b1, '0, q, t0, t1);
    end
  endtask

  task automatic test_contention();
    logic          rr;
    logic [1:0]    exp_rdy, exp_rsp;
    logic [DW-1:0] exp_d, got_d;
    int            w, last_rsp[2];
    rr = ref_rr;
    last_rsp[0] = -1; last_rsp[1] = -1;
    r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 5'd1; r0_req_wdata = '0;
    r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 5'd2; r1_req_wdata = '0;
    for (int o = 0; o < 12; o++) begin
      #1;
      w = int'(rr) ^ ((o / 3) % 2);
      exp_rdy = 2'b00; exp_rsp = 2'b00;
      if (o % 3 == 0) exp_rdy[w] = 1'b1;
      if (o % 3 == 2) exp_rsp[w] = 1'b1;
      total++;
      if ({r1_req_ready, r0_req_ready} !== exp_rdy || {r1_rsp_valid, r0_rsp_valid} !== exp_rsp ||
          mem_read_flag !== (o % 3 == 1)) begin
        bad++;
        $display("FAIL contention o=%0d got rdy=%b rsp=%b rd=%b need rdy=%b rsp=%b rd=%b", o,
                 {r1_req_ready, r0_req_ready}, {r1_rsp_valid, r0_rsp_valid}, mem_read_flag,
                 exp_rdy, exp_rsp, (o % 3 == 1));
      end
      if (o % 3 == 2) begin
        exp_d = ref_mem[(w == 1) ? 2 : 1];
        got_d = (w == 1) ? r1_rsp_rdata : r0_rsp_rdata;
        total++;
        if (got_d !== exp_d) begin
          bad++; $display("FAIL contention_rdata port=%0d got=%h need=%h", w, got_d, exp_d);
        end
        if (last_rsp[w] >= 0) begin
          total++;
          if (cyc - last_rsp[w] != 6) begin
            bad++; $display("FAIL contention_period port=%0d got=%0d need=6", w, cyc - last_rsp[w]);
          end
        end
        last_rsp[w] = cyc;
      end
      @(negedge clk);
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    ref_rr = rr;
  endtask

  task automatic test_back_to_back();
    int t0, t1, ta[3];
    for (int i = 0; i < 3; i++) begin
      serve(1'b0, 1'b1, '0, '{we: 1'b0, addr: AW'(10 + i), wdata: '0}, t0, t1);
      ta[i] = t1;
    end
    total++;
    if (ta[1] - ta[0] != 3 || ta[2] - ta[1] != 3) begin
      bad++;
      $display("FAIL back_to_back_spacing got=%0d,%0d need=3,3", ta[1] - ta[0], ta[2] - ta[1]);
    end
  endtask

  task automatic test_reset_mid();
    int            t0, t1;
    int            seen;
    logic [DW-1:0] d;
    serve(1'b1, 1'b0, '{we: 1'b0, addr: 5'd7, wdata: '0}, '0, t0, t1);
    r1_req_valid = 1'b1; r1_req_we = 1'b0; r1_req_addr = 5'd9; r1_req_wdata = '0;
    #1;
    total++;
    if (r1_req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_accept got=%b need=1", r1_req_ready); end
    @(negedge clk);
    r1_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_read_flag, grant_id} !== 2'b11) begin
      bad++; $display("FAIL rst_mid_access got rd=%b gid=%b need 1 1", mem_read_flag, grant_id);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({busy, mem_read_flag, mem_write_flag, r0_rsp_valid, r1_rsp_valid, grant_id, mem_addr} !== '0) begin
      bad++;
      $display("FAIL rst_mid_state got busy=%b flags=%b%b rsp=%b%b gid=%b addr=%0d need all 0",
               busy, mem_read_flag, mem_write_flag, r1_rsp_valid, r0_rsp_valid, grant_id, mem_addr);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (r1_rsp_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_mid_no_rsp got=%0d pulses need=0", seen); end
    ref_rr = 1'b0;
    serve(1'b1, 1'b1, '{we: 1'b0, addr: 5'd3, wdata: '0}, '{we: 1'b0, addr: 5'd4, wdata: '0}, t0, t1);
    // A write whose ACCESS completes under reset still lands in memory.
    d = $urandom;
    r0_req_valid = 1'b1; r0_req_we = 1'b1; r0_req_addr = 5'd12; r0_req_wdata = d;
    @(negedge clk);
    r0_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[12] = d;
    ref_rr = 1'b0;
    serve(1'b0, 1'b1, '0, '{we: 1'b0, addr: 5'd12, wdata: '0}, t0, t1);
  endtask

  task automatic test_boundary();
    int t0, t1;
    serve(1'b1, 1'b0, '{we: 1'b1, addr: 5'd31, wdata: 32'd1}, '0, t0, t1);
    serve(1'b0, 1'b1, '0, '{we: 1'b0, addr: 5'd31, wdata: '0}, t0, t1);
    total++;
    if (ref_mem[31] !== 32'd1 || r1_rsp_rdata !== 32'd1) begin
      bad++; $display("FAIL addr31_readback got=%h need=00000001", r1_rsp_rdata);
    end
  endtask

  task automatic test_abandon();
    int t0, t1;
    int seen;
    r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 5'd3; r0_req_wdata = '0;
    @(negedge clk);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b1; r1_req_we = 1'b1; r1_req_addr = 5'd4; r1_req_wdata = 32'hFFFF_0000;
    #1;
    total++;
    if (r1_req_ready !== 1'b0) begin bad++; $display("FAIL abandon_ready_busy got=%b need=0", r1_req_ready); end
    @(negedge clk);
    r1_req_valid = 1'b0;
    ref_rr = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || r1_rsp_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abandon_no_txn got=%0d busy cycles need=0", seen); end
    serve(1'b1, 1'b0, '{we: 1'b0, addr: 5'd4, wdata: '0}, '0, t0, t1);
  endtask

  task automatic test_random();
    int         t0, t1;
    logic [1:0] sel;
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom_range(1, 3));
      serve(sel[0], sel[1], rand_req(), rand_req(), t0, t1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0; r0_req_wdata = '0;
    r1_req_valid = 1'b0; r1_req_we = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    test_reset();
    test_write_read();
    test_fill();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    test_abandon();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
